// File: rtl/alien_fire_scheduler_if.sv
// Bundle between the alien formation logic / bullet pool and the enemy fire
// scheduler. The master side is the formation/bullet environment; the slave
// side is the scheduler itself.
interface alien_fire_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int NUM_COLS  = 8
);
    logic                     game_en;
    logic [NUM_COLS-1:0]      col_alive;
    logic [NUM_COLS*10-1:0]   col_x;
    logic [9:0]               bottom_y;
    logic [NUM_SLOTS-1:0]     slot_busy;
    logic [NUM_SLOTS-1:0]     slot_fire;
    logic [9:0]               fire_x;
    logic [9:0]               fire_y;
    logic [7:0]               shot_count;

    modport master (
        output game_en, col_alive, col_x, bottom_y, slot_busy,
        input  slot_fire, fire_x, fire_y, shot_count
    );

    modport slave (
        input  game_en, col_alive, col_x, bottom_y, slot_busy,
        output slot_fire, fire_x, fire_y, shot_count
    );
endinterface

// File: rtl/alien_fire_scheduler.sv
// Enemy fire scheduler: once per fire period it grabs the lowest free bullet
// slot, scans alien columns from a pseudo-random start for a living one and
// launches a single downward bullet from that column's bottom edge.
module alien_fire_scheduler #(
    parameter int          NUM_SLOTS   = 4,
    parameter int          NUM_COLS    = 8,
    parameter logic [23:0] FIRE_PERIOD = 24'd2_500_000,
    parameter logic [9:0]  X_OFFSET    = 10'd15,
    parameter logic [9:0]  Y_OFFSET    = 10'd26,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk_25MHz,
    input  logic                   rst,
    alien_fire_scheduler_if.slave  bus
);

    localparam int CW = $clog2(NUM_COLS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PICK,
        LAUNCH
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [23:0]          timer;
    logic [23:0]          timer_nxt;
    logic [15:0]          lfsr;
    logic                 lfsr_fb;
    logic [CW-1:0]        start_q;
    logic [CW-1:0]        scan_cnt;
    logic [CW-1:0]        scan_col;
    logic [NUM_SLOTS-1:0] slot_q;
    logic [NUM_SLOTS-1:0] lowest_free;
    logic                 col_hit;
    logic                 scan_last;
    logic                 launch_go;
    logic [9:0]           col_x_arr [NUM_COLS];
    logic [9:0]           fire_x_nxt;
    logic [9:0]           fire_y_nxt;

    // Unpack the flat column x bus so the scanned column can be indexed directly
    for (genvar g = 0; g < NUM_COLS; g++) begin : g_colx
        assign col_x_arr[g] = bus.col_x[10*g +: 10];
    end

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign scan_col  = start_q + scan_cnt;
    assign col_hit   = bus.col_alive[scan_col];
    assign scan_last = &scan_cnt;

    // Lowest-index idle bullet slot as a one-hot vector (zero when all busy)
    always_comb begin
        lowest_free = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (!bus.slot_busy[k]) begin
                lowest_free    = '0;
                lowest_free[k] = 1'b1;
            end
        end
    end

    // State register plus period timer, LFSR and the scan context latched on PICK entry
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            timer    <= '0;
            lfsr     <= LFSR_SEED;
            start_q  <= '0;
            scan_cnt <= '0;
            slot_q   <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            lfsr  <= {lfsr[14:0], lfsr_fb};
            if (state != PICK && state_nxt == PICK) begin
                start_q  <= lfsr[CW-1:0];
                slot_q   <= lowest_free;
                scan_cnt <= '0;
            end else if (state == PICK) begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // Next-state and timer: halting play always wins, otherwise wait a period then scan
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        if (!bus.game_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT;
                WAIT: begin
                    if (timer == FIRE_PERIOD - 24'd1) begin
                        state_nxt = PICK;
                    end else begin
                        timer_nxt = timer + 24'd1;
                    end
                end
                PICK: begin
                    if (slot_q == '0) begin
                        state_nxt = WAIT;
                    end else if (col_hit) begin
                        state_nxt = LAUNCH;
                    end else if (scan_last) begin
                        state_nxt = WAIT;
                    end
                end
                LAUNCH:  state_nxt = WAIT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: a launch happens on the PICK->LAUNCH transition
    always_comb begin
        launch_go  = (state == PICK) && (state_nxt == LAUNCH);
        fire_x_nxt = col_x_arr[scan_col] + X_OFFSET;
        fire_y_nxt = bus.bottom_y + Y_OFFSET;
    end

    // Registered outputs so strobe, coordinates and count all appear in the LAUNCH cycle
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            bus.slot_fire  <= '0;
            bus.fire_x     <= '0;
            bus.fire_y     <= '0;
            bus.shot_count <= '0;
        end else begin
            bus.slot_fire <= launch_go ? slot_q : '0;
            if (launch_go) begin
                bus.fire_x     <= fire_x_nxt;
                bus.fire_y     <= fire_y_nxt;
                bus.shot_count <= bus.shot_count + 8'd1;
            end
        end
    end

endmodule
